uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217, meaning clocks per bit period; legal values are >= 4.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range is 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0, where 0 = none, 1 = even and 2 = odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 or 2.
REQ-005 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port i_RX_Serial, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port o_RX_DV, output, 1 bit: one-cycle frame-complete strobe.
REQ-009 The block SHALL have port o_RX_Byte, output, DATA_BITS wide: received data, LSB-first on the line.
REQ-010 The block SHALL have port o_Parity_Err, output, 1 bit: parity mismatch on the last frame.
REQ-011 The block SHALL have port o_Frame_Err, output, 1 bit: a stop bit was sampled low on the last frame.
REQ-012 The block SHALL have port o_RX_Busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 i_RX_Serial SHALL pass through a 2-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY_B, STOP and DONE.
REQ-015 A bit counter (0..DATA_BITS-1), a stop counter and a clock counter sized clog2(CLKS_PER_BIT) SHALL be present.
REQ-016 In IDLE, a synced line value of 0 SHALL cause a transition to START with the clock counter set to 0.
REQ-017 START SHALL count to (CLKS_PER_BIT-1)/2 (mid-bit), with the following transitions:
- If the synced line is still 0, go to DATA with the clock counter cleared.
- If it is 1, the event is a glitch: go to IDLE with no strobe and no flag change.
REQ-018 DATA SHALL count CLKS_PER_BIT clocks, then sample one bit into position bit_counter of the shift register.
- After bit DATA_BITS-1 is sampled, go to PARITY_B if PARITY != 0; otherwise go to STOP.
REQ-019 PARITY_B SHALL sample one bit after CLKS_PER_BIT clocks.
- Error is the XOR of data and parity bit: even mode errors when it is 1, odd mode errors when it is 0.
REQ-020 STOP SHALL sample STOP_BITS bits, each after CLKS_PER_BIT clocks; any stop sample of 0 latches a frame error.
- After the last stop sample, go to DONE.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE. During that cycle:
- o_RX_DV = 1.
- o_RX_Byte, o_Parity_Err and o_Frame_Err are updated together.
REQ-022 o_RX_DV SHALL be high only in DONE, for exactly one cycle per accepted frame.
REQ-023 Data and error flags SHALL hold their values until the next DONE and SHALL be delivered even when an error is flagged.
REQ-024 o_Parity_Err SHALL be constant 0 when PARITY = 0.
REQ-025 The block SHALL NOT wait for line idle after STOP, so back-to-back frames with no idle gap are received without loss.
REQ-026 A low line in IDLE on the cycle after DONE SHALL start a new frame normally.
REQ-027 A line held low (break) SHALL produce one frame with o_RX_Byte = 0 and o_Frame_Err = 1.
- The block then re-enters START while the line remains low.

Reset
REQ-028 Assertion of i_Rst_L = 0 SHALL immediately force the following, at any point including mid-frame:
- State IDLE; all counters 0; shift register 0.
- Outputs o_RX_DV = 0, o_RX_Byte = 0, o_Parity_Err = 0, o_Frame_Err = 0, o_RX_Busy = 0.
REQ-029 A partially received frame SHALL be discarded on reset; no strobe is issued for it after deassertion.

Verification
REQ-030 8N1, CLKS_PER_BIT = 8, send 0x3F -> single o_RX_DV pulse, o_RX_Byte = 0x3F, both error flags 0.
REQ-031 8E1, send 0xA5 with parity bit 1 (wrong) -> o_RX_Byte = 0xA5, o_Parity_Err = 1; next frame 0x01 with parity 1 -> o_Parity_Err = 0.
REQ-032 7O2, send 0x55 with the second stop bit 0 -> o_RX_Byte = 0x55, o_Frame_Err = 1, o_Parity_Err = 0.
REQ-033 8N1, 2-clock low glitch on the idle line -> no o_RX_DV, o_RX_Busy returns to 0 within CLKS_PER_BIT/2 + 3 clocks.
REQ-034 8N1, two back-to-back frames 0x12 and 0x34 with zero idle gap -> two o_RX_DV pulses carrying 0x12 then 0x34.
REQ-035 Reset asserted during data bit 4 of frame 0xFF, then frame 0x0F sent -> exactly one o_RX_DV pulse, o_RX_Byte = 0x0F.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits.
// Mid-bit sampling off a 2-flop synchronized line; results are published on a one-cycle DONE strobe.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_RX_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY_B = 3'd3,
        STOP     = 3'd4,
        DONE     = 3'd5
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_par_out;
    logic                 r_frm_out;

    state_t               w_state;
    logic [CNT_W-1:0]     w_clk_cnt;
    logic [BIT_W-1:0]     w_bit_cnt;
    logic                 w_stop_cnt;
    logic [DATA_BITS-1:0] w_shift;
    logic                 w_par_err;
    logic                 w_frm_err;
    logic                 w_bit_tick;

    // State and datapath registers; published results load on entry to DONE
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_byte     <= '0;
            r_par_out  <= 1'b0;
            r_frm_out  <= 1'b0;
        end else begin
            r_sync1    <= i_RX_Serial;
            r_sync2    <= r_sync1;
            r_state    <= w_state;
            r_clk_cnt  <= w_clk_cnt;
            r_bit_cnt  <= w_bit_cnt;
            r_stop_cnt <= w_stop_cnt;
            r_shift    <= w_shift;
            r_par_err  <= w_par_err;
            r_frm_err  <= w_frm_err;
            if (w_state == DONE) begin
                r_byte    <= w_shift;
                r_par_out <= w_par_err;
                r_frm_out <= w_frm_err;
            end
        end
    end

    assign w_bit_tick = (r_clk_cnt == FULL_CNT);

    always_comb begin
        w_state    = r_state;
        w_clk_cnt  = r_clk_cnt;
        w_bit_cnt  = r_bit_cnt;
        w_stop_cnt = r_stop_cnt;
        w_shift    = r_shift;
        w_par_err  = r_par_err;
        w_frm_err  = r_frm_err;
        case (r_state)
            IDLE: begin
                if (!r_sync2) begin
                    w_state   = START;
                    w_clk_cnt = '0;
                end
            end
            START: begin
                if (r_clk_cnt == HALF_CNT) begin
                    w_clk_cnt = '0;
                    if (!r_sync2) begin
                        w_state    = DATA;
                        w_bit_cnt  = '0;
                        w_stop_cnt = 1'b0;
                        w_shift    = '0;
                        w_par_err  = 1'b0;
                        w_frm_err  = 1'b0;
                    end else begin
                        w_state = IDLE;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_clk_cnt            = '0;
                    w_shift[r_bit_cnt]   = r_sync2;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt = '0;
                        w_state   = (PARITY != 0) ? PARITY_B : STOP;
                    end else begin
                        w_bit_cnt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + 1'b1;
                end
            end
            PARITY_B: begin
                if (w_bit_tick) begin
                    w_clk_cnt = '0;
                    w_state   = STOP;
                    // Even mode expects an even total of ones, odd mode an odd total
                    if (PARITY == 2) w_par_err = ~(^r_shift ^ r_sync2);
                    else             w_par_err = ^r_shift ^ r_sync2;
                end else begin
                    w_clk_cnt = r_clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    w_clk_cnt = '0;
                    if (!r_sync2) w_frm_err = 1'b1;
                    if (r_stop_cnt == LAST_STOP) begin
                        w_stop_cnt = 1'b0;
                        w_state    = DONE;
                    end else begin
                        w_stop_cnt = 1'b1;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + 1'b1;
                end
            end
            DONE:    w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    always_comb begin
        o_RX_DV      = (r_state == DONE);
        o_RX_Busy    = (r_state != IDLE);
        o_RX_Byte    = r_byte;
        o_Parity_Err = (PARITY == 0) ? 1'b0 : r_par_out;
        o_Frame_Err  = r_frm_out;
    end

endmodule
